// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and bus widths for the MEM-stage load/store controller.
// Load/store type codes, FSM state encoding, and an alignment helper.
// Pure definitions; no logic of its own.
package mem_access_ctrl_pkg;

  localparam int LOAD_TYPE_BUS = 3;
  localparam int ADDR_LOW_BUS  = 3;
  localparam int DATA_BUS      = 64;
  localparam int STRB_BUS      = 8;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LD   = 3'b100;
  localparam logic [2:0] LD_LBU  = 3'b101;
  localparam logic [2:0] LD_LHU  = 3'b110;
  localparam logic [2:0] LD_LWU  = 3'b111;

  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_SB   = 3'b001;
  localparam logic [2:0] ST_SH   = 3'b010;
  localparam logic [2:0] ST_SW   = 3'b011;
  localparam logic [2:0] ST_SD   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  // Natural alignment check; the store type takes precedence over the load type.
  function automatic logic is_misaligned(input logic [2:0] ld, input logic [2:0] st,
                                         input logic [2:0] a);
    logic [1:0] sz;
    sz = 2'd0;
    if (st != ST_NONE) begin
      case (st)
        ST_SH:   sz = 2'd1;
        ST_SW:   sz = 2'd2;
        ST_SD:   sz = 2'd3;
        default: sz = 2'd0;
      endcase
    end else begin
      case (ld)
        LD_LH, LD_LHU: sz = 2'd1;
        LD_LW, LD_LWU: sz = 2'd2;
        LD_LD:         sz = 2'd3;
        default:       sz = 2'd0;
      endcase
    end
    case (sz)
      2'd1:    is_misaligned = a[0] != 1'b0;
      2'd2:    is_misaligned = a[1:0] != 2'b00;
      2'd3:    is_misaligned = a != 3'b000;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Store lane alignment: shifts LSB-aligned data to its byte lane and builds strobes.
// Purely combinational, zero latency.
// No flow control; lane bits shifted past bit 7 are dropped.
module mem_access_ctrl_store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]          store_type_i,
  input  logic [2:0]          addr_low_i,
  input  logic [DATA_BUS-1:0] wdata_i,
  output logic [DATA_BUS-1:0] wdata_o,
  output logic [STRB_BUS-1:0] wstrb_o
);

  // Lane shift of write data and per-size strobe pattern (zero for non-stores).
  always_comb begin
    wdata_o = wdata_i << {addr_low_i, 3'b000};
    case (store_type_i)
      ST_SB:   wstrb_o = 8'h01 << addr_low_i;
      ST_SH:   wstrb_o = 8'h03 << addr_low_i;
      ST_SW:   wstrb_o = 8'h0F << addr_low_i;
      ST_SD:   wstrb_o = 8'hFF;
      default: wstrb_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: one access in flight, valid/ready request then response.
// Load with ready=1 and next-cycle response: done_o 3 cycles after acceptance; timeout aborts.
// Stalls the pipeline from acceptance until DONE. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid_i,
  input  logic [LOAD_TYPE_BUS-1:0] load_type_i,
  input  logic [2:0]               store_type_i,
  input  logic [DATA_BUS-1:0]      addr_i,
  input  logic [DATA_BUS-1:0]      wdata_i,
  output logic                     stall_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [DATA_BUS-1:0]      req_addr_o,
  output logic                     req_wen_o,
  output logic [DATA_BUS-1:0]      req_wdata_o,
  output logic [STRB_BUS-1:0]      req_wstrb_o,
  input  logic                     resp_valid_i,
  input  logic [DATA_BUS-1:0]      resp_rdata_i,
  output logic [ADDR_LOW_BUS-1:0]  ld_addr_low_o,
  output logic [LOAD_TYPE_BUS-1:0] ld_type_o,
  output logic [DATA_BUS-1:0]      ld_rdata_o,
  output logic                     done_o,
  output logic                     bus_err_o,
  output logic                     misalign_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [DATA_BUS-1:0]      addr_q, wdata_q, ld_rdata_q;
  logic [ADDR_LOW_BUS-1:0]  addr_low_q, ld_addr_low_q;
  logic [LOAD_TYPE_BUS-1:0] ld_type_q, ld_type_out_q;
  logic [STRB_BUS-1:0]      wstrb_q;
  logic                     wen_q, err_q;
  logic                     access, is_store, timeout, mis_now;
  logic [DATA_BUS-1:0]      al_wdata;
  logic [STRB_BUS-1:0]      al_wstrb;

  assign is_store = store_type_i != ST_NONE;
  assign access   = mem_valid_i & ((load_type_i != LD_NONE) | is_store);
  assign timeout  = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis_now    = is_misaligned(load_type_i, store_type_i, addr_i[2:0]);
  assign misalign_o = done_o & mis_q;
`else
  assign mis_now    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  mem_access_ctrl_store_align u_align (
    .store_type_i (store_type_i),
    .addr_low_i   (addr_i[2:0]),
    .wdata_i      (wdata_i),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/stall outputs.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    req_valid_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = access;
        if (access) state_d = mis_now ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall_o     = 1'b1;
        req_valid_o = 1'b1;
        if (req_ready_i) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        stall_o = 1'b1;
        if (resp_valid_i || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, timeout counter and the downstream load-result hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      addr_q        <= '0;
      addr_low_q    <= '0;
      ld_type_q     <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      err_q         <= 1'b0;
      ld_addr_low_q <= '0;
      ld_type_out_q <= '0;
      ld_rdata_q    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            addr_q     <= {addr_i[DATA_BUS-1:3], 3'b000};
            addr_low_q <= addr_i[2:0];
            ld_type_q  <= is_store ? LD_NONE : load_type_i;
            wen_q      <= is_store;
            wdata_q    <= al_wdata;
            wstrb_q    <= al_wstrb;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis_q      <= mis_now;
`endif
          end
        end
        S_WAIT_RESP: begin
          // A response arriving on the timeout cycle still counts as success.
          if (resp_valid_i) begin
            if (!wen_q) begin
              ld_rdata_q    <= resp_rdata_i;
              ld_addr_low_q <= addr_low_q;
              ld_type_out_q <= ld_type_q;
            end
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_addr_o    = addr_q;
  assign req_wen_o     = wen_q;
  assign req_wdata_o   = wdata_q;
  assign req_wstrb_o   = wstrb_q;
  assign ld_addr_low_o = ld_addr_low_q;
  assign ld_type_o     = ld_type_out_q;
  assign ld_rdata_o    = ld_rdata_q;
  assign bus_err_o     = done_o & err_q;

endmodule
